mem_wait_ctrl: RTL and testbench

Parametrised data-memory stage controller for the ARM pipeline. It replaces the single-cycle data memory with a word-addressed array that has a configurable access latency. While a load or store is in flight it holds `ready` low; the top level drives the whole-pipeline freeze from `!ready`. It sits between EXE_Stage_Reg and Data_Memory_Reg and owns the memory array.

---
 rtl/arm_pkg.sv | 20 ++
 rtl/mem_wait_array.sv | 42 ++++
 rtl/mem_wait_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_wait_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_pkg
// Brief    : Shared types and default widths for the ARM pipeline memory stage.
// Revision : 1.0
// ============================================================================
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    localparam int c_DATA_W    = 32;
    localparam int c_ADDR_W    = 32;
    localparam int c_BASE_ADDR = 1024;

endpackage : arm_pkg
`default_nettype wire

// File: rtl/mem_wait_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_array
// Brief    : Word array with synchronous write and a registered, write-first read port.
// Revision : 1.0
// ============================================================================
module mem_wait_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Contents are deliberately not reset so they survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_en) begin
            r_rdata <= i_we ? i_wdata : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : mem_wait_array
`default_nettype wire

// File: rtl/mem_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_ctrl
// Brief    : Multi-cycle data-memory stage; holds ready low while an access is
//            in flight. Define MEM_READ_BUFFER_EN for a one-entry read buffer.
// Revision : 1.0
// ============================================================================
module mem_wait_ctrl
    import arm_pkg::*;
#(
    parameter int          DATA_W      = c_DATA_W,
    parameter int          ADDR_W      = c_ADDR_W,
    parameter int          DEPTH       = 64,
    parameter int unsigned BASE_ADDR   = c_BASE_ADDR,
    parameter int          WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] alu_res,
    input  logic [DATA_W-1:0] val_rm,
    output logic [DATA_W-1:0] rd_data,
    output logic              ready,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    mem_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_wr;

    logic [ADDR_W-1:0] w_off;
    logic [IDX_W-1:0]  w_idx;
    logic              w_unused_off;
    logic              w_req;
    logic              w_hit;
    logic              w_arr_en;
    logic [DATA_W-1:0] w_arr_rd;
    logic              w_ready;

    // Out-of-range addresses simply wrap onto the array.
    assign w_off        = alu_res - ADDR_W'(BASE_ADDR);
    assign w_idx        = w_off[IDX_W+1:2];
    assign w_unused_off = ^{w_off[ADDR_W-1:IDX_W+2], w_off[1:0]};
    assign w_req        = mem_r_en | mem_w_en;

    // Array is touched only on the final access cycle; reset blocks an in-flight store.
    assign w_arr_en = (r_state == ACCESS) && (r_cnt == '0) && !rst;

    mem_wait_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_arr_en),
        .i_we    (r_is_wr),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_is_wr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && !w_hit) begin
                        r_idx   <= w_idx;
                        r_wdata <= val_rm;
                        r_is_wr <= mem_w_en;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= ACCESS;
                        r_busy  <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_ready = 1'b1;
        case (r_state)
            IDLE:    w_ready = w_hit | !w_req;
            ACCESS:  w_ready = 1'b0;
            DONE:    w_ready = 1'b1;
            default: w_ready = 1'b1;
        endcase
    end

`ifdef MEM_READ_BUFFER_EN
    logic              r_buf_vld;
    logic [IDX_W-1:0]  r_buf_tag;
    logic [DATA_W-1:0] r_buf_data;

    assign w_hit = (r_state == IDLE) && mem_r_en && !mem_w_en &&
                   r_buf_vld && (r_buf_tag == w_idx);

    // A completed miss load fills the entry from the array read register in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_vld <= 1'b0;
        end else if ((r_state == DONE) && !r_is_wr) begin
            r_buf_vld  <= 1'b1;
            r_buf_tag  <= r_idx;
            r_buf_data <= w_arr_rd;
        end else if (w_arr_en && r_is_wr && r_buf_vld && (r_buf_tag == r_idx)) begin
            r_buf_data <= r_wdata;
        end
    end

    assign rd_data = w_hit ? r_buf_data : w_arr_rd;
`else
    assign w_hit   = 1'b0;
    assign rd_data = w_arr_rd;
`endif

    assign ready = w_ready;
    assign busy  = r_busy;

endmodule : mem_wait_ctrl
`default_nettype wire

// File: tb/tb_mem_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wait_ctrl
// Brief    : Self-checking bench for mem_wait_ctrl (WAIT_CYCLES=4, DEPTH=64).
// Revision : 1.0
// ============================================================================
module tb_mem_wait_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_res;
    logic [31:0] val_rm;
    logic [31:0] rd_data;
    logic        ready;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_wt;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        int          wt;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

`ifdef MEM_READ_BUFFER_EN
    localparam int HIT_WT = 0;
`else
    localparam int HIT_WT = 5;
`endif

    mem_wait_ctrl #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .DEPTH       (64),
        .BASE_ADDR   (1024),
        .WAIT_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_r_en (mem_r_en),
        .mem_w_en (mem_w_en),
        .alu_res  (alu_res),
        .val_rm   (val_rm),
        .rd_data  (rd_data),
        .ready    (ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; holds the request until ready, then releases it after that edge.
    task automatic run_op(input string nm, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input int exp_wt);
        exp_t        e;
        int          wt;
        logic        done;
        logic        bz1;
        logic [31:0] got;
        sb.push_back('{exp_rd, exp_wt});
        mem_r_en = r;
        mem_w_en = w;
        alu_res  = a;
        val_rm   = d;
        wt   = 0;
        done = 1'b0;
        bz1  = 1'b0;
        got  = '0;
        while (!done && wt <= 40) begin
            @(negedge clk);
            if (wt == 1) bz1 = busy;
            if (ready) begin
                done = 1'b1;
                got  = rd_data;
            end else begin
                wt++;
            end
        end
        e = sb.pop_front();
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=no_ready required=ready_within_%0d", nm, e.wt);
        end else begin
            chk({nm, "_rd"}, got, e.rd);
            chk({nm, "_wait"}, 32'(wt), 32'(e.wt));
            if (e.wt > 1) chk({nm, "_busy"}, {31'd0, bz1}, 32'd1);
        end
        @(posedge clk);
        #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"st1024",  1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'hDEADBEEF, 5};
        vecs[1] = '{"ld1024",  1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 5};
        vecs[2] = '{"st1028",  1'b0, 1'b1, 32'd1028, 32'h11112222, 32'h11112222, 5};
        vecs[3] = '{"ld1028",  1'b1, 1'b0, 32'd1028, 32'h0,        32'h11112222, 5};
        vecs[4] = '{"st1032",  1'b0, 1'b1, 32'd1032, 32'h0BADF00D, 32'h0BADF00D, 5};
        vecs[5] = '{"rw1036",  1'b1, 1'b1, 32'd1036, 32'h55AA55AA, 32'h55AA55AA, 5};
        vecs[6] = '{"ld1036",  1'b1, 1'b0, 32'd1036, 32'h0,        32'h55AA55AA, 5};

        rst      = 1'b1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        alu_res  = '0;
        val_rm   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_rd",    rd_data,        32'd0);

        @(posedge clk);
        #1;
        // Each vector starts in the IDLE cycle straight after the previous DONE.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].name, vecs[i].r, vecs[i].w, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_wt);
        end

        // Reset while ACCESS with counter = 2 aborts the store.
        mem_w_en = 1'b1;
        alu_res  = 32'd1032;
        val_rm   = 32'h12345678;
        @(negedge clk);
        chk("abort_c0_ready", {31'd0, ready}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort_c2_busy", {31'd0, busy}, 32'd1);
        rst      = 1'b1;
        mem_w_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy",  {31'd0, busy},  32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_rd",    rd_data,        32'd0);
        @(posedge clk);
        #1;
        run_op("ld1032_old", 1'b1, 1'b0, 32'd1032, 32'h0, 32'h0BADF00D, 5);
        run_op("ld1280_wrap", 1'b1, 1'b0, 32'd1280, 32'h0, 32'hDEADBEEF, 5);
        run_op("ld1024_rep", 1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, HIT_WT);
        run_op("st1024_cafe", 1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 32'hCAFEF00D, 5);
        run_op("ld1024_cafe", 1'b1, 1'b0, 32'd1024, 32'h0, 32'hCAFEF00D, HIT_WT);

        @(negedge clk);
        chk("end_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_wait_ctrl
`default_nettype wire
